// File: rtl/period_load_arbiter.sv
// Round-robin arbiter and range clamp for the frequency counter's period port.
// Two requesters (A: host/config, B: front-panel presets) each hold req high with a
// stable period until they see a one-cycle ack. The winner's period is clamped to
// [MIN_PERIOD, MAX_PERIOD] and written to the counter with a one-cycle period_load strobe.
// A hold-off of HOLDOFF cycles then separates it from the next load.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_a/period_a/ack_a  requester A handshake and requested period
//   req_b/period_b/ack_b  requester B handshake and requested period
//   period, period_load   configuration value and load strobe to the counter
//   busy                  high while loading or holding off
//   clamped               last loaded value was forced into range
module period_load_arbiter #(
   parameter int unsigned BITS           = 12,
   parameter int unsigned DEFAULT_PERIOD = 1200,
   parameter int unsigned MIN_PERIOD     = 10,
   parameter int unsigned MAX_PERIOD     = 4095,
   parameter int unsigned HOLDOFF        = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_a,
   input  logic [BITS-1:0] period_a,
   output logic            ack_a,
   input  logic            req_b,
   input  logic [BITS-1:0] period_b,
   output logic            ack_b,
   output logic [BITS-1:0] period,
   output logic            period_load,
   output logic            busy,
   output logic            clamped
);

   localparam int unsigned CW = $clog2(HOLDOFF + 1);
   localparam logic [BITS-1:0] MinVal = BITS'(MIN_PERIOD);
   localparam logic [BITS-1:0] MaxVal = BITS'(MAX_PERIOD);
   localparam logic [BITS-1:0] DefVal = BITS'(DEFAULT_PERIOD);
   localparam logic [CW-1:0]   HoldInit = CW'(HOLDOFF - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rr_b_q, rr_b_d;     // 1: B wins a tie
   logic [BITS-1:0] period_q, period_d;
   logic            clamped_q, clamped_d;
   logic            load_q, load_d;
   logic            ack_a_q, ack_a_d;
   logic            ack_b_q, ack_b_d;
   logic            busy_q, busy_d;
   logic            grant_b;
   logic [BITS-1:0] raw;

   assign grant_b = req_b & (~req_a | rr_b_q);
   assign raw     = grant_b ? period_b : period_a;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_b_d    = rr_b_q;
      period_d  = period_q;
      clamped_d = clamped_q;
      load_d    = 1'b0;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      case (state_q)
         StIdle: begin
            // Outputs are registered, so the strobe/ack for the LOAD cycle are
            // computed here at the grant edge.
            if (req_a || req_b) begin
               state_d = StLoad;
               load_d  = 1'b1;
               ack_a_d = ~grant_b;
               ack_b_d = grant_b;
               rr_b_d  = ~grant_b;
               if (raw < MinVal) begin
                  period_d  = MinVal;
                  clamped_d = 1'b1;
               end else if (raw > MaxVal) begin
                  period_d  = MaxVal;
                  clamped_d = 1'b1;
               end else begin
                  period_d  = raw;
                  clamped_d = 1'b0;
               end
            end
         end
         StLoad: begin
            state_d = StHold;
            cnt_d   = HoldInit;
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rr_b_q    <= 1'b0;
         period_q  <= DefVal;
         clamped_q <= 1'b0;
         load_q    <= 1'b0;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_b_q    <= rr_b_d;
         period_q  <= period_d;
         clamped_q <= clamped_d;
         load_q    <= load_d;
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
         busy_q    <= busy_d;
      end
   end

   assign period      = period_q;
   assign period_load = load_q;
   assign ack_a       = ack_a_q;
   assign ack_b       = ack_b_q;
   assign busy        = busy_q;
   assign clamped     = clamped_q;

endmodule

// File: tb/tb_period_load_arbiter.sv
// Bench for period_load_arbiter: directed scenarios followed by random requester traffic.
// A reference model schedules grants by edge number and pushes the expected loads into a
// queue. A monitor pops that queue on every strobe/ack and checks every cycle that
// period, clamped and busy hold their expected values.
module tb_period_load_arbiter;
   localparam int HOLDOFF = 16;
   localparam int MIN_P   = 10;
   localparam int MAX_P   = 4095;
   localparam int DEF_P   = 1200;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [11:0] period_a = '0, period_b = '0;
   logic        ack_a, ack_b, period_load, busy, clamped;
   logic [11:0] period;

   period_load_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req_a(req_a), .period_a(period_a), .ack_a(ack_a),
      .req_b(req_b), .period_b(period_b), .ack_b(ack_b),
      .period(period), .period_load(period_load), .busy(busy), .clamped(clamped)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {int cyc; bit is_b; int val; bit clamp;} exp_t;
   exp_t q[$];
   int   cyc = 0;
   int   next_ok = 0;
   int   g_cyc = 0;
   bit   g_valid = 0;
   bit   rr_b = 0;
   int   m_period = DEF_P;
   bit   m_clamp = 0;
   bit   busy_exp = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         next_ok  = 0;
         g_valid  = 0;
         rr_b     = 0;
         m_period = DEF_P;
         m_clamp  = 0;
         busy_exp = 0;
      end else begin
         cyc++;
         if (cyc >= next_ok && (req_a || req_b)) begin
            bit take_b;
            int v;
            exp_t e;
            take_b = req_b && (!req_a || rr_b);
            v = take_b ? int'(period_b) : int'(period_a);
            e.cyc = cyc;
            e.is_b = take_b;
            if (v < MIN_P) begin
               e.val = MIN_P; e.clamp = 1;
            end else if (v > MAX_P) begin
               e.val = MAX_P; e.clamp = 1;
            end else begin
               e.val = v; e.clamp = 0;
            end
            q.push_back(e);
            rr_b     = !take_b;
            next_ok  = cyc + HOLDOFF + 2;
            g_cyc    = cyc;
            g_valid  = 1;
            m_period = e.val;
            m_clamp  = e.clamp;
         end
         busy_exp = g_valid && (cyc - g_cyc <= HOLDOFF);
      end
   end

   // ---------------- monitor ----------------
   int strobe_cyc[$];
   bit strobe_b[$];

   always @(negedge clk) begin
      if (reset_n) begin
         chk("busy", int'(busy), int'(busy_exp));
         if (period_load || ack_a || ack_b) begin
            if (q.size() == 0) begin
               chk("unexpected_load", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("load_cycle", cyc, e.cyc);
               chk("load_strobe", int'(period_load), 1);
               chk("ack_a", int'(ack_a), int'(!e.is_b));
               chk("ack_b", int'(ack_b), int'(e.is_b));
               chk("load_period", int'(period), e.val);
               chk("load_clamped", int'(clamped), int'(e.clamp));
            end
            strobe_cyc.push_back(cyc);
            strobe_b.push_back(ack_b);
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("missed_load", 0, 1);
            void'(q.pop_front());
         end
         chk("period_hold", int'(period), m_period);
         chk("clamped_hold", int'(clamped), int'(m_clamp));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_req(input bit who_b, input logic [11:0] val, input int exp_val,
                         input bit exp_clamp);
      bit seen = 0;
      if (who_b) begin req_b = 1; period_b = val; end
      else       begin req_a = 1; period_a = val; end
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk); #1;
         if ((who_b && ack_b) || (!who_b && ack_a)) begin
            seen = 1;
            chk("req_period", int'(period), exp_val);
            chk("req_clamped", int'(clamped), int'(exp_clamp));
         end
      end
      if (who_b) req_b = 0; else req_a = 0;
      if (!seen) begin
         tests++; fails++;
         $display("FAIL req_timeout: got no ack expected ack for value %0d", val);
      end
   endtask

   function automatic logic [11:0] rand_val();
      case ($urandom_range(5))
         0:       return 12'd0;
         1:       return 12'(MIN_P - 1);
         2:       return 12'(MIN_P);
         3:       return 12'(MAX_P);
         default: return 12'($urandom_range(4095));
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int base;
      bit done;
      #12;
      @(negedge clk); #1;
      reset_n = 1;

      // Quiet after reset: monitor checks period/busy and the absence of strobes.
      idle(50);
      chk("reset_period", int'(period), DEF_P);

      // Both requesters held: grants alternate A,B,A starting with A.
      base = strobe_cyc.size();
      req_a = 1; period_a = 12'd300;
      req_b = 1; period_b = 12'd700;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk); #1;
         if (strobe_cyc.size() >= base + 3) done = 1;
      end
      req_a = 0; req_b = 0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL fair_timeout: got %0d loads expected 3", strobe_cyc.size() - base);
      end else begin
         chk("fair_first_a", int'(strobe_b[base]), 0);
         chk("fair_second_b", int'(strobe_b[base+1]), 1);
         chk("fair_third_a", int'(strobe_b[base+2]), 0);
         chk("fair_gap1", strobe_cyc[base+1] - strobe_cyc[base], 18);
         chk("fair_gap2", strobe_cyc[base+2] - strobe_cyc[base+1], 18);
      end
      idle(25);

      // Single request and clamp boundaries.
      do_req(0, 12'd500, 500, 0);
      idle(25);
      do_req(1, 12'd3, 10, 1);
      do_req(0, 12'd10, 10, 0);
      do_req(0, 12'd4095, 4095, 0);
      do_req(1, 12'd0, 10, 1);
      idle(25);

      // Request raised during HOLD waits for the hold-off to expire.
      do_req(0, 12'd1000, 1000, 0);
      do_req(1, 12'd2000, 2000, 0);
      chk("hold_gap", strobe_cyc[$] - strobe_cyc[$-1], 18);
      idle(25);

      // Reset during the LOAD cycle drops the strobe/ack and restores the default.
      req_a = 1; period_a = 12'd900;
      @(posedge clk); #2;
      reset_n = 0;
      #1;
      chk("rst_load", int'(period_load), 0);
      chk("rst_ack_a", int'(ack_a), 0);
      chk("rst_period", int'(period), DEF_P);
      chk("rst_busy", int'(busy), 0);
      chk("rst_clamped", int'(clamped), 0);
      req_a = 0;
      idle(3);
      reset_n = 1;
      idle(2);
      do_req(0, 12'd900, 900, 0);
      idle(25);

      // Random traffic from both requesters.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk); #1;
         if (req_a && ack_a) begin
            if ($urandom_range(3) != 0) req_a = 0;
         end else if (!req_a && $urandom_range(7) == 0) begin
            req_a = 1; period_a = rand_val();
         end
         if (req_b && ack_b) begin
            if ($urandom_range(3) != 0) req_b = 0;
         end else if (!req_b && $urandom_range(7) == 0) begin
            req_b = 1; period_b = rand_val();
         end
      end
      req_a = 0; req_b = 0;
      idle(40);
      chk("drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/period_load_arbiter.md
Name: period_load_arbiter

Overview:
- Controller in front of the frequency counter's `period`/`period_load` configuration port.
- Arbitrates round-robin between two independent requesters: A, the host/config interface, and B, the front-panel preset logic.
- Range-clamps the requested measurement period and issues single-cycle load pulses.
- Enforces a hold-off between successive loads so the counter is never reconfigured back-to-back.

Parameters:
- BITS, 12, width of period values; matches the counter's period port.
- DEFAULT_PERIOD, 1200, period driven out of reset; equals the counter's own reset period.
- MIN_PERIOD, 10, smallest period forwarded; lower requests are clamped up.
- MAX_PERIOD, 4095, largest period forwarded; higher requests are clamped down. Must be ≤ 2^BITS-1.
- HOLDOFF, 16, cycles spent in HOLD after each load. Must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A load request; held high until ack_a
- period_a  in  BITS  requested period from A; stable while req_a high
- ack_a  out  1  one-cycle grant/complete pulse to A
- req_b  in  1  requester B load request; held high until ack_b
- period_b  in  BITS  requested period from B; stable while req_b high
- ack_b  out  1  one-cycle grant/complete pulse to B
- period  out  BITS  period value to the counter; holds last loaded value
- period_load  out  1  one-cycle load strobe to the counter
- busy  out  1  high in LOAD and HOLD
- clamped  out  1  high if the last loaded value was clamped

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=IDLE
  - period=DEFAULT_PERIOD
  - period_load=0, ack_a=0, ack_b=0
  - busy=0, clamped=0
  - rr pointer=A
  - hold counter=0
  - No strobe is emitted on reset release.
- All outputs are registered.
- State machine:
  - IDLE
    - If any req is high at a clk edge, grant one requester.
    - If both requests are high, grant the requester selected by the rr pointer; otherwise grant the single active requester.
    - Capture the granted period value, clamped to [MIN_PERIOD, MAX_PERIOD], and go to LOAD.
    - Otherwise remain in IDLE.
  - LOAD (exactly 1 cycle)
    - period_load=1, period=clamped value, and the matching ack=1, all in this cycle.
    - clamped=1 if the raw value was out of range, else 0.
    - rr pointer moves to the non-granted requester.
    - Go to HOLD with counter=HOLDOFF-1.
  - HOLD
    - period_load=0, acks=0.
    - Counter decrements each cycle; when it reaches 0, go to IDLE.
    - HOLD lasts exactly HOLDOFF cycles.
    - Requests are ignored in HOLD; they are neither acked nor lost. A request still held at return to IDLE competes normally.
- Timing:
  - Latency: a req sampled in IDLE at edge k gives period_load/ack high during cycle k+1.
  - Minimum spacing between period_load pulses is HOLDOFF+2 cycles.
- Protocol:
  - A requester deasserts req on the edge after it sees ack.
  - A req held past ack is treated as a new request once back in IDLE.
  - Data is sampled only at the grant edge; later changes to period_x are ignored.
- Boundaries:
  - Value equal to MIN_PERIOD or MAX_PERIOD: passed unclamped, clamped=0.
  - period_x=0: loads MIN_PERIOD, clamped=1.
  - Between loads, period and clamped hold their values.
  - Fairness: with both requests permanently high, grants strictly alternate A,B,A,B… starting with A after reset.
  - Reset mid-LOAD or mid-HOLD: immediate return to reset values. The in-flight ack and strobe are dropped, and period reverts to DEFAULT_PERIOD.

Test Plan:
- Reset release, no requests for 50 cycles -> period=1200, period_load never 1, busy=0.
- req_a with period_a=500 at IDLE edge k -> cycle k+1: period_load=1, ack_a=1, period=500, clamped=0. busy stays high for 1+16 cycles, then 0.
- req_a and req_b high simultaneously (A=300, B=700), held after ack -> loads 300, 700, 300 with pulses exactly 18 cycles apart; ack_a and ack_b alternate.
- period_b=3 -> period=10, clamped=1. Then period_a=10 -> period=10, clamped=0. Then period_a=4095 -> 4095, clamped=0.
- req_b asserted during HOLD -> no ack until HOLD ends. Grant follows in the first IDLE cycle, and period_load occurs one cycle later.
- reset_n pulled low during the LOAD cycle of period_a=900 -> period_load and ack_a drop immediately, period=1200. After release, a fresh req_a=900 loads normally.
